// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared 640x480@60 timing constants and lock-state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int H_SYNC   = 96;
   localparam int V_SYNC   = 2;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_edge
//  Purpose  : Registers one sync/blank input and flags its rising/falling edges.
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_edge (
   input  logic vga_clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic r_prev;

   // Resetting both stages low can only fake a rising edge, never a falling one.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         sync   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         sync   <= din;
         r_prev <= sync;
      end
   end

   assign rise = sync & ~r_prev;
   assign fall = r_prev & ~sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_monitor
//  Purpose  : Recovers pixel coordinates from VGA sync/blank, measures timing
//             and declares lock against the expected raster.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_monitor #(
   parameter int H_TOTAL     = vga_pkg::H_TOTAL,
   parameter int V_TOTAL     = vga_pkg::V_TOTAL,
   parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int LOCK_FRAMES = 2,
   parameter int CW          = 11
) (
   input  logic          vga_clk,
   input  logic          reset,
   input  logic          vga_hs,
   input  logic          vga_vs,
   input  logic          vga_blank_n,
   output logic [9:0]    pix_x,
   output logic [9:0]    pix_y,
   output logic          pix_valid,
   output logic          frame_start,
   output logic [CW-1:0] h_total_meas,
   output logic [CW-1:0] v_total_meas,
   output logic [CW-1:0] h_active_meas,
   output logic [CW-1:0] v_active_meas,
   output logic          locked,
   output logic          timing_err
);

   import vga_pkg::*;

   localparam int            MW          = $clog2(LOCK_FRAMES + 1);
   localparam logic [CW-1:0] c_max       = '1;
   localparam logic [CW-1:0] c_h_total   = CW'(H_TOTAL);
   localparam logic [CW-1:0] c_v_total   = CW'(V_TOTAL);
   localparam logic [CW-1:0] c_h_active  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] c_v_active  = CW'(V_ACTIVE);

   logic w_hs_s, w_hs_rise, w_hs_fall;
   logic w_vs_s, w_vs_rise, w_vs_fall;
   logic w_blank_s, w_blank_rise, w_blank_fall;
   logic w_unused_edges;

   vga_sync_edge u_hs_edge (
      .vga_clk (vga_clk), .reset (reset), .din (vga_hs),
      .sync    (w_hs_s),  .rise  (w_hs_rise), .fall (w_hs_fall)
   );

   vga_sync_edge u_vs_edge (
      .vga_clk (vga_clk), .reset (reset), .din (vga_vs),
      .sync    (w_vs_s),  .rise  (w_vs_rise), .fall (w_vs_fall)
   );

   vga_sync_edge u_blank_edge (
      .vga_clk (vga_clk),   .reset (reset), .din (vga_blank_n),
      .sync    (w_blank_s), .rise  (w_blank_rise), .fall (w_blank_fall)
   );

   assign w_unused_edges = ^{w_hs_s, w_hs_rise, w_vs_s, w_vs_rise};

   logic [CW-1:0] r_hcnt, r_lcnt, r_acnt, r_vacnt;
   logic [CW-1:0] w_hcnt_inc, w_lcnt_inc, w_acnt_inc, w_vacnt_inc;
   logic [CW-1:0] w_lcnt_nx, w_vacnt_nx, w_h_total_nx, w_h_active_nx;

   assign w_hcnt_inc  = (r_hcnt  == c_max) ? c_max : r_hcnt  + CW'(1);
   assign w_lcnt_inc  = (r_lcnt  == c_max) ? c_max : r_lcnt  + CW'(1);
   assign w_acnt_inc  = (r_acnt  == c_max) ? c_max : r_acnt  + CW'(1);
   assign w_vacnt_inc = (r_vacnt == c_max) ? c_max : r_vacnt + CW'(1);

   // Same-cycle line edges are folded in before a frame edge closes the count.
   assign w_lcnt_nx     = w_hs_fall    ? w_lcnt_inc  : r_lcnt;
   assign w_vacnt_nx    = w_blank_fall ? w_vacnt_inc : r_vacnt;
   assign w_h_total_nx  = w_hs_fall    ? w_hcnt_inc  : h_total_meas;
   assign w_h_active_nx = w_blank_fall ? r_acnt      : h_active_meas;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_hcnt        <= '0;
         r_lcnt        <= '0;
         r_acnt        <= '0;
         r_vacnt       <= '0;
         h_total_meas  <= '0;
         v_total_meas  <= '0;
         h_active_meas <= '0;
         v_active_meas <= '0;
         frame_start   <= 1'b0;
         pix_valid     <= 1'b0;
         pix_x         <= '0;
         pix_y         <= '0;
      end else begin
         r_hcnt      <= w_hs_fall ? '0 : w_hcnt_inc;
         r_lcnt      <= w_vs_fall ? '0 : w_lcnt_nx;
         r_vacnt     <= w_vs_fall ? '0 : w_vacnt_nx;
         frame_start <= w_vs_fall;
         pix_valid   <= w_blank_s;

         if (w_blank_fall)   r_acnt <= '0;
         else if (w_blank_s) r_acnt <= w_acnt_inc;

         if (w_hs_fall)    h_total_meas  <= w_hcnt_inc;
         if (w_blank_fall) h_active_meas <= r_acnt;
         if (w_vs_fall) begin
            v_total_meas  <= w_lcnt_nx;
            v_active_meas <= w_vacnt_nx;
         end

         if (w_blank_rise)   pix_x <= '0;
         else if (w_blank_s) pix_x <= pix_x + 10'd1;

         if (w_vs_fall)         pix_y <= '0;
         else if (w_blank_fall) pix_y <= pix_y + 10'd1;
      end
   end

   // A saturated measurement means the input was lost, so it can never match.
   function automatic logic meas_eq(input logic [CW-1:0] m, input logic [CW-1:0] e);
      return (m == e) && (m != c_max);
   endfunction

   logic w_all_match, w_line_bad, w_hs_lost;

   assign w_all_match = meas_eq(w_h_total_nx,  c_h_total)  &&
                        meas_eq(w_lcnt_nx,     c_v_total)  &&
                        meas_eq(w_h_active_nx, c_h_active) &&
                        meas_eq(w_vacnt_nx,    c_v_active);
   assign w_line_bad  = w_hs_fall && !meas_eq(w_hcnt_inc, c_h_total);
   assign w_hs_lost   = (r_hcnt == c_max);

   lock_state_t r_state, w_state_nx;
   logic [MW-1:0] r_match_cnt, w_match_nx, w_match_inc;
   logic          w_locked_nx, w_err_nx;

   assign w_match_inc = r_match_cnt + MW'(1);

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_state     <= SEARCH;
         r_match_cnt <= '0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_match_cnt <= w_match_nx;
         locked      <= w_locked_nx;
         timing_err  <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_match_nx  = r_match_cnt;
      w_locked_nx = locked;
      w_err_nx    = timing_err;
      case (r_state)
         SEARCH: begin
            if (w_vs_fall) begin
               w_state_nx = ACQUIRE;
               w_match_nx = '0;
            end
         end
         ACQUIRE: begin
            if (w_vs_fall) begin
               if (!w_all_match) begin
                  w_match_nx = '0;
               end else if (w_match_inc == MW'(LOCK_FRAMES)) begin
                  w_state_nx  = LOCKED;
                  w_match_nx  = '0;
                  w_locked_nx = 1'b1;
               end else begin
                  w_match_nx = w_match_inc;
               end
            end
         end
         LOCKED: begin
            if (w_line_bad || w_hs_lost || (w_vs_fall && !w_all_match)) begin
               w_state_nx  = ACQUIRE;
               w_match_nx  = '0;
               w_locked_nx = 1'b0;
               w_err_nx    = 1'b1;
            end
         end
         default: begin
            w_state_nx  = SEARCH;
            w_match_nx  = '0;
            w_locked_nx = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_monitor
//  Purpose  : Directed bench for vga_timing_monitor on a scaled-down raster
//             (40x12 lines, 32x8 active) with a cycle-accurate generator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_monitor;

   localparam int HT  = 40;
   localparam int HA  = 32;
   localparam int HS0 = 34;
   localparam int HS1 = 38;
   localparam int VT  = 12;
   localparam int VA  = 8;
   localparam int VS0 = 9;
   localparam int VS1 = 11;
   localparam int CW  = 11;

   logic          vga_clk     = 1'b0;
   logic          reset       = 1'b1;
   logic          vga_hs      = 1'b1;
   logic          vga_vs      = 1'b1;
   logic          vga_blank_n = 1'b0;
   logic [9:0]    pix_x, pix_y;
   logic          pix_valid, frame_start, locked, timing_err;
   logic [CW-1:0] h_total_meas, v_total_meas, h_active_meas, v_active_meas;

   int n_vec = 0;
   int n_err = 0;
   int gh = 0, gv = 0, stretch_v = -1, h_len = HT;
   bit hold = 1'b0;

   vga_timing_monitor #(
      .H_TOTAL (HT), .V_TOTAL (VT), .H_ACTIVE (HA), .V_ACTIVE (VA),
      .LOCK_FRAMES (2), .CW (CW)
   ) dut (
      .vga_clk       (vga_clk),
      .reset         (reset),
      .vga_hs        (vga_hs),
      .vga_vs        (vga_vs),
      .vga_blank_n   (vga_blank_n),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_valid     (pix_valid),
      .frame_start   (frame_start),
      .h_total_meas  (h_total_meas),
      .v_total_meas  (v_total_meas),
      .h_active_meas (h_active_meas),
      .v_active_meas (v_active_meas),
      .locked        (locked),
      .timing_err    (timing_err)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Drive the pixel at (gv,gh), wait one clock, then advance the raster.
   task automatic step();
      vga_blank_n = (gh < HA) && (gv < VA);
      vga_hs      = hold || !(gh >= HS0 && gh < HS1);
      vga_vs      = hold || !(gv >= VS0 && gv < VS1);
      @(posedge vga_clk);
      #1;
      gh++;
      if (gh >= ((gv == stretch_v) ? h_len + 1 : h_len)) begin
         gh = 0;
         gv = (gv == VT - 1) ? 0 : gv + 1;
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic goto_pos(input int v, input int h);
      int k = 0;
      while (!(gv == v && gh == h) && k < 2000) begin
         step();
         k++;
      end
      check("goto_reach", int'(gv == v && gh == h), 1);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_pix_x"},   int'(pix_x), 0);
      check({pfx, "_pix_y"},   int'(pix_y), 0);
      check({pfx, "_valid"},   int'(pix_valid), 0);
      check({pfx, "_fstart"},  int'(frame_start), 0);
      check({pfx, "_htot"},    int'(h_total_meas), 0);
      check({pfx, "_vtot"},    int'(v_total_meas), 0);
      check({pfx, "_hact"},    int'(h_active_meas), 0);
      check({pfx, "_vact"},    int'(v_active_meas), 0);
      check({pfx, "_locked"},  int'(locked), 0);
      check({pfx, "_err"},     int'(timing_err), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      steps(3);
      check_zero("rst");
      reset = 1'b0;

      // Lock: ACQUIRE at 1st vs, match at 2nd, lock 2 cycles after the 3rd
      goto_pos(VS0, 0); steps(2);
      check("vs1_locked", int'(locked), 0);
      goto_pos(VS0, 0); steps(2);
      check("vs2_locked", int'(locked), 0);
      goto_pos(VS0, 0); step();
      check("vs3_early", int'(locked), 0);
      step();
      check("vs3_locked", int'(locked), 1);
      check("vs3_fstart", int'(frame_start), 1);
      step();
      check("fstart_1cyc", int'(frame_start), 0);
      check("meas_htot", int'(h_total_meas), HT);
      check("meas_vtot", int'(v_total_meas), VT);
      check("meas_hact", int'(h_active_meas), HA);
      check("meas_vact", int'(v_active_meas), VA);
      check("lock_err", int'(timing_err), 0);

      // Coordinates in a locked frame
      goto_pos(0, 0); steps(2);
      check("first_valid", int'(pix_valid), 1);
      check("first_x", int'(pix_x), 0);
      check("first_y", int'(pix_y), 0);
      goto_pos(VA - 1, HA - 1); steps(2);
      check("last_valid", int'(pix_valid), 1);
      check("last_x", int'(pix_x), HA - 1);
      check("last_y", int'(pix_y), VA - 1);
      step();
      check("blank_valid", int'(pix_valid), 0);
      check("blank_x_hold", int'(pix_x), HA - 1);
      check("blank_y_inc", int'(pix_y), VA);
      goto_pos(VS0, 0); steps(2);
      check("fs_pulse", int'(frame_start), 1);
      check("fs_y_zero", int'(pix_y), 0);
      check("fs_locked", int'(locked), 1);

      // Stretch the last measured line of a frame to HT+1
      goto_pos(0, 0);
      stretch_v = 7;
      goto_pos(8, HS0);
      stretch_v = -1;
      step();
      check("str_pre_locked", int'(locked), 1);
      step();
      check("str_locked", int'(locked), 0);
      check("str_err", int'(timing_err), 1);
      check("str_htot", int'(h_total_meas), HT + 1);
      goto_pos(VS0, 0); steps(2);
      check("str_vs0_locked", int'(locked), 0);
      goto_pos(VS0, 0); steps(2);
      check("str_vs1_locked", int'(locked), 0);
      goto_pos(VS0, 0); steps(2);
      check("str_relock", int'(locked), 1);
      check("str_err_sticky", int'(timing_err), 1);

      // Sync held inactive while locked: only hcnt saturation can drop lock
      goto_pos(2, 0);
      hold = 1'b1;
      steps(1900);
      check("hold_pre_locked", int'(locked), 1);
      steps(200);
      check("hold_locked", int'(locked), 0);
      check("hold_err", int'(timing_err), 1);
      check("hold_htot", int'(h_total_meas), HT);
      check("hold_vtot", int'(v_total_meas), VT);
      hold = 1'b0;
      goto_pos(gv, HS0); steps(2);
      check("hold_sat_meas", int'(h_total_meas), 2047);

      // One-cycle reset mid-frame
      goto_pos(3, 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_zero("mrst");
      goto_pos(VS0, 0); steps(2);
      check("mrst_vs1", int'(locked), 0);
      check("mrst_vs1_fs", int'(frame_start), 1);
      goto_pos(VS0, 0); steps(2);
      check("mrst_vs2", int'(locked), 0);
      goto_pos(VS0, 0); steps(2);
      check("mrst_vs3", int'(locked), 1);
      check("mrst_err", int'(timing_err), 0);

      // Short line period with correct active width never locks
      goto_pos(0, 0);
      h_len = HT - 1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int f = 0; f < 4; f++) begin
         goto_pos(VS0, 0); steps(2);
         check("short_locked", int'(locked), 0);
         check("short_err", int'(timing_err), 0);
      end
      check("short_htot", int'(h_total_meas), HT - 1);
      check("short_hact", int'(h_active_meas), HA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side counterpart of the VGA timing generator.
- Observes vga_hs, vga_vs and vga_blank_n, and recovers per-pixel x/y coordinates.
- Measures line period, frame height and active area, then declares lock against expected 640x480@60 timing.
- Used by the capture/overlay path and on-chip bring-up to confirm the display timing is sane.

Parameters:
H_TOTAL, 800, expected clocks per line
V_TOTAL, 525, expected lines per frame
H_ACTIVE, 640, expected blank_n-high clocks per line
V_ACTIVE, 480, expected lines containing active pixels
LOCK_FRAMES, 2, consecutive matching frames needed to assert lock
CW, 11, measurement counter width; counters saturate at 2^CW-1

Ports:
vga_clk  in  1  pixel clock (25 MHz); the only clock
reset  in  1  synchronous, active-high reset
vga_hs  in  1  horizontal sync, active low
vga_vs  in  1  vertical sync, active low
vga_blank_n  in  1  high during active video
pix_x  out  10  active-pixel column of the sample currently on pix_valid
pix_y  out  10  active-line row of that sample
pix_valid  out  1  registered blank_n
frame_start  out  1  one-cycle pulse on the vs falling edge
h_total_meas  out  CW  last measured clocks between hs falling edges
v_total_meas  out  CW  last measured lines between vs falling edges
h_active_meas  out  CW  blank_n-high clocks in the last completed active line
v_active_meas  out  CW  active lines in the last completed frame
locked  out  1  timing matches parameters
timing_err  out  1  sticky; set on any loss of lock, cleared only by reset

Behaviour:
- Input stage: hs/vs/blank_n are registered once (s_*). Previous copies (p_*) drive the edge detectors. Outputs reflect port activity with exactly 2 cycles of latency.
- Reset (synchronous, vga_clk edge with reset=1):
  - All outputs and counters go to 0; locked=0; timing_err=0; FSM=SEARCH.
  - Reset asserted mid-frame discards all partial measurements.
- Horizontal measurement:
  - hcnt increments every cycle and saturates at 2^CW-1.
  - On hs falling edge: h_total_meas<=hcnt+1, hcnt<=0, lcnt<=lcnt+1 (saturating).
- Active width:
  - acnt counts cycles with s_blank_n=1.
  - On blank_n falling edge: h_active_meas<=acnt, acnt<=0, vacnt<=vacnt+1.
- Vertical measurement, on vs falling edge:
  - v_total_meas<=lcnt and v_active_meas<=vacnt, then both counters clear.
  - frame_start pulses for one cycle.
  - If an hs falling edge lands in the same cycle, count that line first; lcnt then clears.
- Coordinates:
  - pix_x resets to 0 on blank_n rising edge and increments each cycle blank_n stays high.
  - pix_y increments on blank_n falling edge and resets to 0 on vs falling edge.
  - Both hold while blanked.
  - pix_x/pix_y/pix_valid stay aligned on the same cycle.
- Lock FSM (updated on vs falling edge, after the new measurements are taken):
  - SEARCH: the first vs edge only moves to ACQUIRE with match_cnt=0, because no full frame has been measured yet.
  - ACQUIRE: "all match" means h_total_meas=H_TOTAL, v_total_meas=V_TOTAL, h_active_meas=H_ACTIVE and v_active_meas=V_ACTIVE.
    - All match: match_cnt++. When it reaches LOCK_FRAMES, go to LOCKED with locked=1.
    - Any mismatch: match_cnt=0 and stay in ACQUIRE.
  - LOCKED: on any of the following, locked<=0, timing_err<=1, go to ACQUIRE with match_cnt=0:
    - any measurement mismatch at a vs edge;
    - any hs edge with hcnt+1≠H_TOTAL;
    - hcnt saturating (hs lost).
- Width rule: comparisons are zero-extended to CW. Saturated values never match.

Decomposition:
- vga_pkg holds:
  - 640x480 timing localparams (H_TOTAL, V_TOTAL, H_ACTIVE, V_ACTIVE, H_SYNC=96, V_SYNC=2);
  - lock_state_t enum {SEARCH, ACQUIRE, LOCKED}.
- The generator shares the same package constants.
- One sub-module: vga_sync_edge (input register, previous copy, rise/fall pulses), instantiated three times for hs/vs/blank_n.

Test Plan:
- Drive from the existing 800x525 generator after reset → locked rises 2 cycles after the 3rd vs falling edge. Measurements read 800/525/640/480. timing_err stays 0.
- Check coordinates in a locked frame: first blank_n-high cycle → pix_x=0, pix_y=0. The last active pixel reads pix_x=639, pix_y=479. On frame_start, pix_y returns to 0.
- While locked, stretch one line to 801 clocks → at that hs edge locked=0 and timing_err=1. Regains lock after 2 clean frames while timing_err stays 1.
- Hold hs high while locked → hcnt saturates at 2047, locked drops, and h_total_meas keeps its last value of 800.
- Assert reset for 1 cycle mid-frame → next cycle all outputs are 0 and state=SEARCH. Lock needs 3 vs edges again.
- Feed 640-clock blank_n with a 799-clock line period → ACQUIRE never locks: match_cnt stays 0 and locked stays 0 indefinitely.
